// File: rtl/cc_apb_master_pkg.sv
// Shared definitions for the crypto-cell APB initiator: FSM encoding,
// region decode constants and the address-map check.
package cc_apb_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_GAP    = 2'd3
  } cc_state_e;

  localparam logic [3:0]  RNG             = 4'h1;
  localparam logic [3:0]  CRY_CTL         = 4'h8;
  localparam logic [11:0] CLK_STATUS_ADDR = 12'h824;

  // Only the TRNG and crypto-control regions are decoded by the slave mux.
  function automatic logic addr_mapped(input logic [11:0] addr);
    return (addr[11:8] == RNG) || (addr[11:8] == CRY_CTL);
  endfunction

endpackage

// File: rtl/cc_apb_poll_ctr.sv
// Poll bookkeeping: saturating read counter, inter-read gap timer and the
// masked-match / read-limit comparators consumed by the master FSM.
module cc_apb_poll_ctr #(
  parameter logic [15:0] POLL_LIMIT = 16'd1024,
  parameter logic [3:0]  POLL_GAP   = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        access_i,
  input  logic        in_gap_i,
  input  logic [31:0] prdata_i,
  input  logic [31:0] mask_i,
  input  logic [31:0] match_i,
  output logic        poll_match_o,
  output logic        poll_limit_hit_o,
  output logic        gap_done_o
);

  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;

  // Count value including the read completing this cycle, saturating at all-ones.
  assign rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
  assign gap_cnt_d = gap_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rd_cnt_q <= '0;
    end else if (access_i) begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !in_gap_i) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign poll_match_o     = ((prdata_i ^ match_i) & mask_i) == 32'd0;
  assign poll_limit_hit_o = rd_cnt_d >= POLL_LIMIT;
  assign gap_done_o       = in_gap_i &&
                            ((POLL_GAP == 4'd0) || (gap_cnt_q == POLL_GAP - 4'd1));

endmodule

// File: rtl/cc_apb_master.sv
// Command-driven APB initiator for the crypto-cell bus: single reads/writes
// plus hardware polled reads with masked match and read-count timeout.
module cc_apb_master
  import cc_apb_defs::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'd1024,
  parameter logic [3:0]  POLL_GAP   = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_poll,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_mask,
  input  logic [31:0] req_match,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        rsp_unmapped,
  output logic        cc_psel,
  output logic        cc_penable,
  output logic        cc_pwrite,
  output logic [11:0] cc_paddr,
  output logic [31:0] cc_pwdata,
  input  logic [31:0] cc_prdata
);

  cc_state_e   state_q, state_d;
  logic        write_q, poll_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, mask_q, match_q;
  logic        rsp_valid_q, rsp_timeout_q, rsp_unmapped_q;
  logic [31:0] rsp_rdata_q;

  logic accept, done, timeout_d, access, in_gap, bus_active;
  logic poll_match, poll_limit_hit, gap_done;

  cc_apb_poll_ctr #(
    .POLL_LIMIT(POLL_LIMIT),
    .POLL_GAP  (POLL_GAP)
  ) u_poll_ctr (
    .clk             (clk),
    .rst             (rst),
    .clr_i           (accept),
    .access_i        (access),
    .in_gap_i        (in_gap),
    .prdata_i        (cc_prdata),
    .mask_i          (mask_q),
    .match_i         (match_q),
    .poll_match_o    (poll_match),
    .poll_limit_hit_o(poll_limit_hit),
    .gap_done_o      (gap_done)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    in_gap    = 1'b0;
    done      = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        access = 1'b1;
        if (!poll_q || poll_match) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (poll_limit_hit) begin
          done      = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (POLL_GAP == 4'd0) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        in_gap = 1'b1;
        if (gap_done) state_d = ST_SETUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      poll_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // A poll is always a read, whatever req_write says.
        write_q <= req_write && !req_poll;
        poll_q  <= req_poll;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mask_q  <= req_mask;
        match_q <= req_match;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_timeout_q  <= 1'b0;
      rsp_unmapped_q <= 1'b0;
    end else begin
      rsp_valid_q <= done;
      if (done) begin
        rsp_rdata_q    <= write_q ? 32'd0 : cc_prdata;
        rsp_timeout_q  <= timeout_d;
        rsp_unmapped_q <= !addr_mapped(addr_q);
      end
    end
  end

  // Bus fields are zero outside SETUP/ACCESS to match the decoder's gating.
  assign bus_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign cc_psel    = bus_active;
  assign cc_penable = (state_q == ST_ACCESS);
  assign cc_pwrite  = bus_active && write_q;
  assign cc_paddr   = bus_active ? addr_q  : 12'd0;
  assign cc_pwdata  = bus_active ? wdata_q : 32'd0;

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign rsp_unmapped = rsp_unmapped_q;

endmodule

// File: tb/tb_cc_apb_master.sv
// Directed bench for cc_apb_master: writes, reads, polls (match and timeout),
// unmapped access and reset during a poll, against a small slave model.
module tb_cc_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_poll = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0, req_mask = '0, req_match = '0;
  logic        rsp_valid, rsp_timeout, rsp_unmapped;
  logic [31:0] rsp_rdata;
  logic        cc_psel, cc_penable, cc_pwrite;
  logic [11:0] cc_paddr;
  logic [31:0] cc_pwdata;
  logic [31:0] cc_prdata;

  cc_apb_master #(.POLL_LIMIT(16'd4), .POLL_GAP(4'd2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_poll(req_poll), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_mask(req_mask), .req_match(req_match),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .rsp_unmapped(rsp_unmapped),
    .cc_psel(cc_psel), .cc_penable(cc_penable), .cc_pwrite(cc_pwrite),
    .cc_paddr(cc_paddr), .cc_pwdata(cc_pwdata), .cc_prdata(cc_prdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Cycle counter and slave model: reads of mapped regions return rd_vals in order.
  int          cyc = 0;
  int          rd_cnt = 0;
  int          rd_base = 0;
  logic [31:0] rd_vals [8];
  int          rd_idx;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cc_psel && cc_penable && !cc_pwrite) rd_cnt <= rd_cnt + 1;
  end

  always @* begin
    rd_idx = (rd_cnt - rd_base) & 7;
    cc_prdata = 32'd0;
    if (cc_psel && !cc_pwrite && (cc_paddr[11:8] == 4'h1 || cc_paddr[11:8] == 4'h8))
      cc_prdata = rd_vals[rd_idx];
  end

  // Bus monitor.
  int          n_setup_tot = 0, n_acc_tot = 0, n_rsp_tot = 0, idle_bad = 0;
  int          setup_cyc [64];
  logic        last_pwrite;
  logic [11:0] last_paddr;
  logic [31:0] last_pwdata;

  always @(negedge clk) begin
    if (cc_psel && !cc_penable) begin
      setup_cyc[n_setup_tot & 63] = cyc;
      n_setup_tot++;
    end
    if (cc_psel && cc_penable) begin
      n_acc_tot++;
      last_pwrite = cc_pwrite;
      last_paddr  = cc_paddr;
      last_pwdata = cc_pwdata;
    end
    if (!cc_psel && (cc_penable || cc_pwrite || cc_paddr != 12'd0 || cc_pwdata != 32'd0))
      idle_bad++;
    if (rsp_valid) n_rsp_tot++;
  end

  int acc_cyc, rsp_rel, setup0, acc0;

  // Issue a command, wait for its response; returns at the negedge of the rsp_valid cycle.
  task automatic run_cmd(input logic w, input logic p, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] m, input logic [31:0] mt);
    bit got;
    req_write = w; req_poll = p; req_addr = a;
    req_wdata = wd; req_mask = m; req_match = mt;
    req_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    setup0 = n_setup_tot;
    acc0 = n_acc_tot;
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    rsp_rel = cyc - acc_cyc + 1;
    if (!got) check_val("rsp_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic load_slave(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    rd_base = rd_cnt;
    rd_vals[0] = v0; rd_vals[1] = v1; rd_vals[2] = v2;
    for (int i = 3; i < 8; i++) rd_vals[i] = v2;
  endtask

  int first_acc, r0;
  bit hit;

  initial begin
    for (int i = 0; i < 8; i++) rd_vals[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_psel", {31'd0, cc_psel}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Write 0x104 <= DEADBEEF
    run_cmd(1'b1, 1'b0, 12'h104, 32'hDEADBEEF, 32'd0, 32'd0);
    $display("write 0x104 data=0xDEADBEEF rsp_rel=%0d rdata=0x%08h", rsp_rel, rsp_rdata);
    check_val("wr_setups", n_setup_tot - setup0, 32'd1);
    check_val("wr_accesses", n_acc_tot - acc0, 32'd1);
    check_val("wr_pwrite", {31'd0, last_pwrite}, 32'd1);
    check_val("wr_pwdata", last_pwdata, 32'hDEADBEEF);
    check_val("wr_paddr", {20'd0, last_paddr}, 32'h104);
    check_val("wr_setup_rel", setup_cyc[setup0 & 63] - acc_cyc + 1, 32'd1);
    check_val("wr_rsp_rel", rsp_rel, 32'd3);
    check_val("wr_rdata", rsp_rdata, 32'd0);
    check_val("wr_unmapped", {31'd0, rsp_unmapped}, 32'd0);

    // Read 0x100, then a poll accepted in the response cycle
    load_slave(32'h12345678, 32'd0, 32'd0);
    run_cmd(1'b0, 1'b0, 12'h100, 32'd0, 32'd0, 32'd0);
    first_acc = acc_cyc;
    $display("read 0x100 rsp_rel=%0d rdata=0x%08h unmapped=%0d", rsp_rel, rsp_rdata, rsp_unmapped);
    check_val("rd_rdata", rsp_rdata, 32'h12345678);
    check_val("rd_unmapped", {31'd0, rsp_unmapped}, 32'd0);
    check_val("rd_pwrite", {31'd0, last_pwrite}, 32'd0);
    check_val("rd_rsp_rel", rsp_rel, 32'd3);
    check_val("rd_ready_in_rsp", {31'd0, req_ready}, 32'd1);

    // Poll 0x10C mask 1 match 1, slave 0,0,1; req_write=1 must still read
    load_slave(32'd0, 32'd0, 32'd1);
    run_cmd(1'b1, 1'b1, 12'h10C, 32'hA5A5A5A5, 32'd1, 32'd1);
    $display("poll 0x10C rsp_rel=%0d reads=%0d rdata=0x%08h timeout=%0d",
             rsp_rel, n_acc_tot - acc0, rsp_rdata, rsp_timeout);
    check_val("b2b_setup_at_n4", acc_cyc - first_acc + 1, 32'd4);
    check_val("poll_reads", n_acc_tot - acc0, 32'd3);
    check_val("poll_setup1", setup_cyc[setup0 & 63] - acc_cyc + 1, 32'd1);
    check_val("poll_setup2", setup_cyc[(setup0 + 1) & 63] - acc_cyc + 1, 32'd5);
    check_val("poll_setup3", setup_cyc[(setup0 + 2) & 63] - acc_cyc + 1, 32'd9);
    check_val("poll_pwrite", {31'd0, last_pwrite}, 32'd0);
    check_val("poll_rdata", rsp_rdata, 32'd1);
    check_val("poll_timeout", {31'd0, rsp_timeout}, 32'd0);
    check_val("poll_rsp_rel", rsp_rel, 32'd11);

    // Poll that never matches: POLL_LIMIT=4 reads then timeout
    load_slave(32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE);
    run_cmd(1'b0, 1'b1, 12'h10C, 32'd0, 32'd1, 32'd1);
    $display("poll-timeout 0x10C rsp_rel=%0d reads=%0d rdata=0x%08h timeout=%0d",
             rsp_rel, n_acc_tot - acc0, rsp_rdata, rsp_timeout);
    check_val("to_reads", n_acc_tot - acc0, 32'd4);
    check_val("to_timeout", {31'd0, rsp_timeout}, 32'd1);
    check_val("to_rdata", rsp_rdata, 32'hFFFFFFFE);
    check_val("to_setup4", setup_cyc[(setup0 + 3) & 63] - acc_cyc + 1, 32'd13);
    check_val("to_rsp_rel", rsp_rel, 32'd15);

    // Unmapped read 0x300
    load_slave(32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
    run_cmd(1'b0, 1'b0, 12'h300, 32'd0, 32'd0, 32'd0);
    $display("read 0x300 rsp_rel=%0d rdata=0x%08h unmapped=%0d", rsp_rel, rsp_rdata, rsp_unmapped);
    check_val("um_accesses", n_acc_tot - acc0, 32'd1);
    check_val("um_paddr", {20'd0, last_paddr}, 32'h300);
    check_val("um_unmapped", {31'd0, rsp_unmapped}, 32'd1);
    check_val("um_rdata", rsp_rdata, 32'd0);
    check_val("um_timeout", {31'd0, rsp_timeout}, 32'd0);

    // Reset during ACCESS of a poll; req_valid held with rst must not be taken
    @(posedge clk); #1;
    load_slave(32'd0, 32'd0, 32'd0);
    req_write = 1'b0; req_poll = 1'b1; req_addr = 12'h824;
    req_mask = 32'd1; req_match = 32'd1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r0 = n_rsp_tot;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (cc_psel && cc_penable) hit = 1;
    end
    check_val("rst_reached_access", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    req_addr = 12'h100; req_poll = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    check_val("rst_mid_psel", {31'd0, cc_psel}, 32'd0);
    check_val("rst_mid_penable", {31'd0, cc_penable}, 32'd0);
    check_val("rst_mid_paddr", {20'd0, cc_paddr}, 32'd0);
    @(negedge clk);
    check_val("rst_valid_not_taken", {31'd0, cc_psel}, 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_val("rst_release_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_release_psel", {31'd0, cc_psel}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    $display("reset-in-poll responses_after=%0d", n_rsp_tot - r0);
    check_val("rst_no_rsp", n_rsp_tot - r0, 32'd0);
    check_val("idle_bus_zero", idle_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

endmodule
